// File: rtl/csi_tx_sched_if.sv
// Byte-wide valid/ready transmit channel from the CSI scheduler to the line transmitter.
interface csi_tx_sched_if;
    logic [7:0] tx_d;
    logic       tx_valid;
    logic       tx_sof;
    logic       tx_eof;
    logic       tx_ready;

    modport master (output tx_d, output tx_valid, output tx_sof, output tx_eof, input  tx_ready);
    modport slave  (input  tx_d, input  tx_valid, input  tx_sof, input  tx_eof, output tx_ready);
endinterface

// File: rtl/csi_tx_sched.sv
// CSI transmit scheduler: arbitrates BTC time-code frames and CCW buffer frames onto
// one byte channel as 10-byte frames (header, 8 payload bytes, XOR checksum).
module csi_tx_sched #(
    parameter logic [7:0]  CCW_HDR = 8'hC1,
    parameter logic [7:0]  BTC_HDR = 8'hB1,
    parameter int unsigned PEND_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csi_on,
    input  logic              csi_btc_en,
    input  logic              csi_tm_en,
    input  logic              tm,
    input  logic [63:0]       sys_time,
    input  logic              ccw_accepted,
    input  logic              ccw_buf_empty,
    input  logic [7:0]        ccw_d,
    output logic              ccw_rdreq,
    csi_tx_sched_if.master    tx,
    output logic              busy,
    output logic [PEND_W-1:0] ccw_pending,
    output logic              btc_miss,
    output logic              ccw_ovf,
    output logic              ccw_underrun
);
    typedef enum logic [2:0] {IDLE, HDR, BTC_DAT, CCW_RD, CCW_CAP, CCW_DAT, CHK} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state_q, state_d;
    logic              btc_req_q, btc_req_d;
    logic [63:0]       snap_q, snap_d;
    logic [63:0]       shift_q, shift_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        chk_q, chk_d;
    logic              is_btc_q, is_btc_d;
    logic              und_q, und_d;
    logic              miss_q, miss_d;
    logic              ovf_q, ovf_d;
    logic              btc_fire, btc_start, ccw_start;
    logic [7:0]        hdr_byte;

    assign btc_fire    = tm & csi_tm_en & csi_btc_en & csi_on;
    assign hdr_byte    = is_btc_q ? BTC_HDR : CCW_HDR;
    assign busy        = (state_q != IDLE);
    assign ccw_pending = pend_q;
    assign btc_miss    = miss_q;
    assign ccw_ovf     = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            btc_req_q <= 1'b0;
            snap_q    <= '0;
            shift_q   <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
            byte_q    <= '0;
            chk_q     <= '0;
            is_btc_q  <= 1'b0;
            und_q     <= 1'b0;
            miss_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            btc_req_q <= btc_req_d;
            snap_q    <= snap_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            chk_q     <= chk_d;
            is_btc_q  <= is_btc_d;
            und_q     <= und_d;
            miss_q    <= miss_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        btc_req_d    = btc_req_q;
        snap_d       = snap_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        chk_d        = chk_q;
        is_btc_d     = is_btc_q;
        und_d        = und_q;
        miss_d       = 1'b0;
        ovf_d        = 1'b0;
        btc_start    = 1'b0;
        ccw_start    = 1'b0;
        ccw_rdreq    = 1'b0;
        ccw_underrun = 1'b0;
        tx.tx_d      = '0;
        tx.tx_valid  = 1'b0;
        tx.tx_sof    = 1'b0;
        tx.tx_eof    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csi_on) begin
                    if (btc_req_q) begin
                        btc_start = 1'b1;
                        is_btc_d  = 1'b1;
                        shift_d   = snap_q;
                        state_d   = HDR;
                    end else if (pend_q != '0) begin
                        ccw_start = 1'b1;
                        is_btc_d  = 1'b0;
                        state_d   = HDR;
                    end
                end
            end
            HDR: begin
                tx.tx_d     = hdr_byte;
                tx.tx_valid = 1'b1;
                tx.tx_sof   = 1'b1;
                cnt_d       = '0;
                if (tx.tx_ready) begin
                    chk_d   = hdr_byte;
                    state_d = is_btc_q ? BTC_DAT : CCW_RD;
                end
            end
            BTC_DAT: begin
                tx.tx_d     = shift_q[63:56];
                tx.tx_valid = 1'b1;
                if (tx.tx_ready) begin
                    chk_d   = chk_q ^ shift_q[63:56];
                    shift_d = {shift_q[55:0], 8'h00};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = CHK;
                end
            end
            CCW_RD: begin
                // An empty buffer is never read; the byte slot is filled with 0x00 instead.
                ccw_rdreq    = ~ccw_buf_empty;
                ccw_underrun = ccw_buf_empty;
                und_d        = ccw_buf_empty;
                state_d      = CCW_CAP;
            end
            CCW_CAP: begin
                byte_d  = und_q ? 8'h00 : ccw_d;
                state_d = CCW_DAT;
            end
            CCW_DAT: begin
                tx.tx_d     = byte_q;
                tx.tx_valid = 1'b1;
                if (tx.tx_ready) begin
                    chk_d   = chk_q ^ byte_q;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd7) ? CHK : CCW_RD;
                end
            end
            CHK: begin
                tx.tx_d     = chk_q;
                tx.tx_valid = 1'b1;
                tx.tx_eof   = 1'b1;
                if (tx.tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (btc_start || !csi_on) btc_req_d = 1'b0;
        if (btc_fire) begin
            btc_req_d = 1'b1;
            snap_d    = sys_time;
            // A request consumed by a frame start this very cycle is not a miss.
            miss_d    = btc_req_q & ~btc_start;
        end

        if (ccw_accepted && !ccw_start) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else                    pend_d = pend_q + PEND_W'(1);
        end else if (!ccw_accepted && ccw_start) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end
endmodule

// File: doc/csi_tx_sched.md
# csi_tx_sched

Schedules the single byte-wide transmit channel of the collection system imitator (CSI) between two frame sources: board time code (BTC) frames, triggered by time marks, and control command word (CCW) frames, drained from the CCW buffer. The block sits in the `clk_prj` domain, downstream of the USB control registers and upstream of the CSI line transmitter. It builds 10-byte frames (header, 8 payload bytes, checksum) and hands them out over a valid/ready byte interface. A frame is never pre-empted once started.

## Interface
Parameters:
- `CCW_HDR`, 8'hC1, header byte of a CCW frame
- `BTC_HDR`, 8'hB1, header byte of a BTC frame
- `PEND_W`, 3, width of the pending-CCW counter (saturates at 2^PEND_W-1)

Ports:
- `clk` in 1: project clock (`clk_prj`)
- `rst` in 1: asynchronous, active-high reset
- `csi_on` in 1: CSI enabled; gates frame starts
- `csi_btc_en` in 1: BTC frames enabled
- `csi_tm_en` in 1: time-mark input enabled
- `tm` in 1: time-mark strobe, one-cycle pulse
- `sys_time` in 64: system time, MSB byte sent first
- `ccw_accepted` in 1: one-cycle pulse; one complete 8-byte CCW is now in the buffer
- `ccw_buf_empty` in 1: CCW buffer empty
- `ccw_d` in 8: CCW buffer read data, valid the cycle after `ccw_rdreq`
- `ccw_rdreq` out 1: CCW buffer read strobe, one cycle per byte
- `tx_d` out 8: transmit byte
- `tx_valid` out 1: `tx_d` valid
- `tx_sof` out 1: the current byte is a header
- `tx_eof` out 1: the current byte is a checksum
- `tx_ready` in 1: transmitter accepts the byte at this edge
- `busy` out 1: a frame is in progress
- `ccw_pending` out PEND_W: number of queued CCWs
- `btc_miss` out 1: pulse; a pending BTC was overwritten
- `ccw_ovf` out 1: pulse; an accept was lost at saturation
- `ccw_underrun` out 1: pulse; the buffer was empty on a CCW byte read

## Operation
- **BTC request.** `tm & csi_tm_en & csi_btc_en & csi_on` does two things:
  - Snapshots `sys_time` into `snap`.
  - Sets `btc_req`. If `btc_req` was already set, `btc_miss` pulses and `snap` is overwritten.
- **BTC request clearing.** `btc_req` clears when a BTC frame starts, or when `csi_on` is low.
- **Pending counter.**
  - `ccw_accepted` increments the counter; a CCW frame start decrements it.
  - If both occur in the same cycle, the counter is unchanged.
  - At maximum, an accept leaves the counter unchanged and pulses `ccw_ovf`.
- **Arbitration.** Evaluated in IDLE only, and only when `csi_on` = 1. BTC has priority over CCW; CCW is selected when `ccw_pending != 0`. There is no fairness counter.
- **FSM states:** IDLE, HDR, BTC_DAT, CCW_RD, CCW_CAP, CCW_DAT, CHK.
  - IDLE → HDR when a source is selected. For BTC, `snap` is copied into the payload shift register at this point.
  - HDR drives the header with `tx_sof` = 1. On transfer, go to BTC_DAT (BTC frame) or CCW_RD (CCW frame).
  - BTC_DAT drives the payload MSB first. Each transfer shifts by one byte. After the 8th transfer, go to CHK.
  - CCW_RD asserts `ccw_rdreq` for exactly one cycle, then goes to CCW_CAP.
    - If `ccw_buf_empty` = 1 in CCW_RD: no rdreq is issued, `ccw_underrun` pulses, and the byte is substituted with 0x00.
  - CCW_CAP registers `ccw_d` (or 0x00 on underrun) into `tx_d`, then goes to CCW_DAT.
  - CCW_DAT holds the byte until transfer. After a transfer, go to CCW_RD, or to CHK after the 8th byte.
  - CHK drives the checksum with `tx_eof` = 1. On transfer, go to IDLE.
- **Checksum.** XOR of the header and all 8 payload bytes as transmitted, including any 0x00 substitutes.
- **Handshake.**
  - A transfer occurs at an edge where `tx_valid & tx_ready`.
  - `tx_d`, `tx_sof` and `tx_eof` are held stable while `tx_valid` = 1 without `tx_ready`.
  - `tx_valid` is low in IDLE, CCW_RD and CCW_CAP.
- **`csi_on` falling mid-frame.** The current frame completes; no new frame starts.
- **`busy`.** High in every state except IDLE.
- **Byte counter.** 3 bits, reset at HDR, incremented per payload transfer.

## Timing
- **Reset values.** All outputs are 0 (including `tx_d`). FSM = IDLE, `btc_req` = 0, `snap` = 0, pending = 0. Reset mid-frame abandons the frame immediately; there is no recovery of in-flight CCW bytes.
- **BTC latency.** A time mark sampled at edge k, with the FSM idle, gives `tx_valid` high with `tx_d` = `BTC_HDR` after edge k+1.
- **CCW latency.** `ccw_accepted` sampled at edge k, with the FSM idle, gives the header after edge k+1.
- **BTC throughput.** With `tx_ready` held at 1, a BTC frame takes 10 cycles of `tx_valid`, gap-free, then 1 IDLE cycle.
- **CCW throughput.** Each payload byte costs 3 cycles (RD, CAP, DAT) with `tx_ready` = 1, so a CCW frame takes 1 + 24 + 1 = 26 cycles.
- **Frame spacing.** At least one IDLE cycle separates consecutive frames.

## Test plan
- **BTC frame.** `sys_time` = 0x0102030405060708, all enables = 1, single `tm` pulse, `tx_ready` = 1 → bytes B1, 01..08, B9; `tx_sof` on the first byte, `tx_eof` on the last; header one cycle after `tm`.
- **CCW frame.** Buffer preloaded with A1..A8, one `ccw_accepted` → `ccw_rdreq` pulses 8 times; bytes C1, A1..A8, C9; `ccw_pending` goes 1 → 0 at frame start.
- **Priority.** `tm` and `ccw_accepted` in the same cycle → BTC frame first, then the CCW frame after one IDLE cycle; neither is lost.
- **Back-pressure.** `tx_ready` toggling 0/1 per cycle during a BTC frame → identical byte sequence; `tx_d` stable whenever ready = 0.
- **Overflow and miss.**
  - 8 `ccw_accepted` pulses with `csi_on` = 0 → pending saturates at 7 and `ccw_ovf` pulses once.
  - Two `tm` pulses while a CCW frame is busy → `btc_miss` pulses once; the BTC frame carries the second snapshot.
- **Underrun and reset.**
  - Pending = 1 with an empty buffer → 8 × `ccw_underrun`; frame C1, 00×8, C1.
  - `rst` asserted mid-frame → `tx_valid` = 0 immediately; pending = 0.
